wb_line_mem_slave: RTL and testbench



---
 rtl/wb_line_mem_slave.sv | 141 ++++++++++++++
 tb/tb_wb_line_mem_slave.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_line_mem_slave.sv
// Wishbone line-memory responder: 128-bit lines, byte-merged writes under SEL,
// fixed ACK latency, range-checked addresses and saturating access counters.
module wb_line_mem_slave #(
  parameter int ADDR_BITS = 6,
  parameter int LATENCY   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         CYC,
  input  logic         STB,
  input  logic         WE,
  input  logic [11:0]  ADR,
  input  logic [15:0]  SEL,
  input  logic [127:0] DAT_M,
  output logic [127:0] DAT_S,
  output logic         ACK,
  output logic         ERR,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t state, state_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic [11:0]  adr_q;
  logic         we_q;
  logic [15:0]  sel_q;
  logic [127:0] dat_q;
  logic [127:0] dat_s_q;
  logic [15:0]  rd_count_q;
  logic [15:0]  wr_count_q;
  logic [127:0] mem [DEPTH];

  logic                 accept;
  logic                 oor_q;
  logic [11:0]          req_adr;
  logic                 req_we;
  logic                 req_oor;
  logic [ADDR_BITS-1:0] req_idx;
  logic                 enter_resp;
  logic                 write_now;

  // The request feeding the RESP-entry read is the live bus when accepting
  // (LATENCY == 1) and the latched copy otherwise.
  assign accept     = (state == IDLE) && CYC && STB;
  assign req_adr    = accept ? ADR : adr_q;
  assign req_we     = accept ? WE : we_q;
  assign req_oor    = (req_adr >> ADDR_BITS) != 12'd0;
  assign req_idx    = req_adr[ADDR_BITS-1:0];
  assign oor_q      = (adr_q >> ADDR_BITS) != 12'd0;
  assign enter_resp = (state_nxt == RESP);
  assign write_now  = (state == RESP) && we_q && !oor_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (CYC && STB) begin
          cnt_nxt   = LAT_M1;
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!CYC) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nxt = RESP;
          end
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      adr_q   <= 12'd0;
      we_q    <= 1'b0;
      sel_q   <= 16'd0;
      dat_q   <= '0;
      dat_s_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        adr_q <= ADR;
        we_q  <= WE;
        sel_q <= SEL;
        dat_q <= DAT_M;
      end
      dat_s_q <= (enter_resp && !req_we && !req_oor) ? mem[req_idx] : '0;
    end
  end

  // Counters advance on the edge leaving an ACK cycle and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else if (state == RESP && !oor_q) begin
      if (we_q) begin
        if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      end else begin
        if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  // Backing store is deliberately not reset; a reset in RESP drops state to
  // IDLE immediately, so the pending write never reaches this block.
  always_ff @(posedge clk) begin
    if (write_now) begin
      for (int i = 0; i < 16; i++) begin
        if (sel_q[i]) begin
          mem[adr_q[ADDR_BITS-1:0]][8*i +: 8] <= dat_q[8*i +: 8];
        end
      end
    end
  end

  assign DAT_S    = dat_s_q;
  assign ACK      = (state == RESP) && !oor_q;
  assign ERR      = (state == RESP) && oor_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_line_mem_slave.sv
// Randomized scoreboard bench for wb_line_mem_slave: a line-array reference
// model predicts each response; a negedge monitor pops and compares them.
module tb_wb_line_mem_slave;

  localparam int ADDR_BITS = 6;
  localparam int LATENCY   = 3;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         CYC, STB, WE;
  logic [11:0]  ADR;
  logic [15:0]  SEL;
  logic [127:0] DAT_M;
  logic [127:0] DAT_S;
  logic         ACK, ERR;
  logic [15:0]  rd_count, wr_count;

  wb_line_mem_slave #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR),
    .SEL(SEL), .DAT_M(DAT_M), .DAT_S(DAT_S), .ACK(ACK), .ERR(ERR),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_err;
    bit           is_read;
    logic [127:0] data;
    int           due;
    logic [15:0]  rd_before;
    logic [15:0]  wr_before;
  } resp_t;

  resp_t        exp_q[$];
  resp_t        mon_e;
  logic [127:0] model_mem [DEPTH];
  int           model_rd = 0;
  int           model_wr = 0;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every ACK/ERR must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ACK || ERR) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_response", {126'd0, ACK, ERR}, 128'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("resp_cycle", 128'(cyc), 128'(mon_e.due));
          checkOutput("ack", 128'(ACK), 128'(!mon_e.is_err));
          checkOutput("err", 128'(ERR), 128'(mon_e.is_err));
          if (mon_e.is_err || mon_e.is_read) checkOutput("dat_s", DAT_S, mon_e.data);
          checkOutput("rd_count_at_resp", 128'(rd_count), 128'(mon_e.rd_before));
          checkOutput("wr_count_at_resp", 128'(wr_count), 128'(mon_e.wr_before));
        end
      end else if (DAT_S !== 128'd0) begin
        checkOutput("dat_s_idle", DAT_S, 128'd0);
      end
    end
  end

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issue one access starting just after a rising edge; returns one cycle
  // after its response edge. With hold=1 CYC/STB stay high for the next call.
  task automatic applyStimulus(input bit we, input logic [11:0] adr, input logic [15:0] sel,
                               input logic [127:0] dat, input bit hold);
    resp_t e;
    int    idx;
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; SEL = sel; DAT_M = dat;
    idx         = int'(adr) % DEPTH;
    e.is_err    = (int'(adr) >= DEPTH);
    e.is_read   = !we;
    e.due       = cyc + LATENCY;
    e.rd_before = 16'(model_rd);
    e.wr_before = 16'(model_wr);
    e.data      = 128'd0;
    if (!e.is_err) begin
      if (we) begin
        for (int i = 0; i < 16; i++)
          if (sel[i]) model_mem[idx][8*i +: 8] = dat[8*i +: 8];
        if (model_wr < 65535) model_wr++;
      end else begin
        e.data = model_mem[idx];
        if (model_rd < 65535) model_rd++;
      end
    end
    exp_q.push_back(e);
    repeat (LATENCY) @(posedge clk);
    // Scramble the bus while the request is in flight; the latched copy rules.
    WE = ~we; ADR = 12'($urandom); SEL = 16'($urandom); DAT_M = rand_line();
    @(posedge clk); #1;
    if (!hold) begin
      CYC = 1'b0; STB = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    CYC = 1'b0; STB = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] d;
    CYC = 0; STB = 0; WE = 0; ADR = 0; SEL = 0; DAT_M = 0;
    #3;
    checkOutput("reset_ack", 128'(ACK), 128'd0);
    checkOutput("reset_err", 128'(ERR), 128'd0);
    checkOutput("reset_dat_s", DAT_S, 128'd0);
    checkOutput("reset_rd_count", 128'(rd_count), 128'd0);
    checkOutput("reset_wr_count", 128'(wr_count), 128'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Give every line a known value, back to back.
    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 12'(a), 16'hFFFF, rand_line(), a != DEPTH - 1);
    idle(1);

    // Basic write then read.
    applyStimulus(1'b1, 12'h005, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
    applyStimulus(1'b0, 12'h005, 16'h0000, 128'd0, 1'b0);
    checkOutput("basic_line", model_mem[5], 128'h0123456789ABCDEF0123456789ABCDEF);

    // Byte merge.
    applyStimulus(1'b1, 12'h002, 16'hFFFF, {16{8'h11}}, 1'b0);
    applyStimulus(1'b1, 12'h002, 16'h0003, {rand_line() & ~128'hFFFF} | 128'hBEEF, 1'b0);
    applyStimulus(1'b0, 12'h002, 16'h0000, 128'd0, 1'b0);
    checkOutput("merge_line", model_mem[2], 128'h1111111111111111111111111111BEEF);

    // Back-to-back reads with STB held, plus a SEL=0 write.
    applyStimulus(1'b0, 12'h000, 16'h0, 128'd0, 1'b1);
    applyStimulus(1'b0, 12'h001, 16'h0, 128'd0, 1'b1);
    applyStimulus(1'b0, 12'h002, 16'h0, 128'd0, 1'b1);
    applyStimulus(1'b1, 12'h003, 16'h0000, rand_line(), 1'b0);

    // Out of range, then confirm line 0 untouched.
    applyStimulus(1'b1, 12'h040, 16'hFFFF, rand_line(), 1'b0);
    applyStimulus(1'b0, 12'h040, 16'h0, 128'd0, 1'b0);
    applyStimulus(1'b0, 12'h000, 16'h0, 128'd0, 1'b0);

    // Abort: CYC dropped in cycle 1 of a write; no scoreboard entry.
    CYC = 1; STB = 1; WE = 1; ADR = 12'h007; SEL = 16'hFFFF; DAT_M = rand_line();
    @(posedge clk); #1;
    CYC = 0; STB = 0;
    idle(LATENCY + 2);
    applyStimulus(1'b0, 12'h007, 16'h0, 128'd0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      d = rand_line();
      applyStimulus(1'($urandom), ($urandom_range(0, 9) == 0) ? 12'($urandom_range(64, 4095))
                                                              : 12'($urandom_range(0, DEPTH - 1)),
                    16'($urandom), d, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    // Reset while a write waits: no response, line kept, counters cleared.
    CYC = 1; STB = 1; WE = 1; ADR = 12'h009; SEL = 16'hFFFF; DAT_M = rand_line();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rd_count", 128'(rd_count), 128'd0);
    checkOutput("rst_wr_count", 128'(wr_count), 128'd0);
    CYC = 0; STB = 0;
    model_rd = 0; model_wr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    applyStimulus(1'b0, 12'h009, 16'h0, 128'd0, 1'b0);
    checkOutput("rst_rd_after", 128'(rd_count), 128'd1);

    // Saturation: preload the read counter near the top.
    force dut.rd_count_q = 16'hFFFD;
    #1;
    release dut.rd_count_q;
    model_rd = 16'hFFFD;
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, 12'($urandom_range(0, DEPTH - 1)), 16'h0, 128'd0, n != 3);
    idle(2);
    checkOutput("rd_saturated", 128'(rd_count), 128'hFFFF);

    checkOutput("final_rd_count", 128'(rd_count), 128'(model_rd));
    checkOutput("final_wr_count", 128'(wr_count), 128'(model_wr));
    checkOutput("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
